ifu32_fetch: RTL and testbench

- RV32 instruction fetch stage; sits directly upstream of the instruction decoder.
- Holds the PC and issues one-outstanding word reads to instruction memory over a valid/ready request and valid-only response interface.
- Captures the returned instruction and presents it to decode with a valid/ready handshake, pre-split into opcode, funct3 and funct7 fields sized for the decoder (7/4/8 bits).
- Accepts PC redirects from execute (branch/jump) and squashes any in-flight fetch.

---
 rtl/ifu32_pkg.sv | 34 +++
 rtl/ifu32_fetch_split.sv | 27 ++
 rtl/ifu32_fetch.sv | 147 ++++++++++++++
 tb/tb_ifu32_fetch.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu32_pkg.sv
// ============================================================================
// Module   : ifu32_pkg
// Brief    : Shared types and constants for the RV32 fetch stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ifu32_pkg;

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    DRAIN = 3'd3,
    HOLD  = 3'd4
  } state_e;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

  localparam int OPC_LSB = 0;
  localparam int OPC_MSB = 6;
  localparam int F3_LSB  = 12;
  localparam int F3_MSB  = 14;
  localparam int F7_LSB  = 25;
  localparam int F7_MSB  = 31;

  function automatic logic [31:0] pc_align(input logic [31:0] pc);
    return pc & ~32'h0000_0003;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ifu32_fetch_split.sv
// ============================================================================
// Module   : inst_field_split
// Brief    : Splits a raw RV32 instruction into decoder-width opcode/funct3/funct7.
// Revision : 1.0
// ============================================================================
`default_nettype none

module inst_field_split
  import ifu32_pkg::*;
(
  input  logic [31:0] inst,
  output logic [6:0]  opcode,
  output logic [3:0]  funct3,
  output logic [7:0]  funct7
);

  // Register/immediate fields belong to later decode stages.
  logic w_unused_bits;

  assign opcode        = inst[OPC_MSB:OPC_LSB];
  assign funct3        = {1'b0, inst[F3_MSB:F3_LSB]};
  assign funct7        = {1'b0, inst[F7_MSB:F7_LSB]};
  assign w_unused_bits = ^{inst[24:15], inst[11:7]};

endmodule

`default_nettype wire

// File: rtl/ifu32_fetch.sv
// ============================================================================
// Module   : ifu32_fetch
// Brief    : RV32 fetch stage, one outstanding read, redirect squash.
//            Optional misaligned-redirect trap: IFU32_MISALIGN_TRAP_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ifu32_fetch
  import ifu32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_inst,
  output logic [6:0]      out_opcode,
  output logic [3:0]      out_funct3,
  output logic [7:0]      out_funct7
`ifdef IFU32_MISALIGN_TRAP_EN
  ,
  output logic            out_misalign
`endif
);

  state_e          r_state;
  state_e          w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] r_inst;
  logic [XLEN-1:0] w_inst_nxt;
  logic            r_mis;
  logic            w_mis_nxt;
  logic            w_redir_mis;
  logic [XLEN-1:0] w_redir_pc;

`ifdef IFU32_MISALIGN_TRAP_EN
  // Raw target is kept so the trapped instruction reports the exact PC.
  assign w_redir_mis = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign w_redir_pc  = redirect_pc;
`else
  assign w_redir_mis = 1'b0;
  assign w_redir_pc  = pc_align(redirect_pc);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= BOOT;
      r_pc    <= RESET_PC;
      r_inst  <= '0;
      r_mis   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_inst  <= w_inst_nxt;
      r_mis   <= w_mis_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_inst_nxt  = r_inst;
    w_mis_nxt   = r_mis;

    if (redirect_valid && (r_state != BOOT)) begin
      w_pc_nxt  = w_redir_pc;
      w_mis_nxt = w_redir_mis;
    end

    case (r_state)
      BOOT: w_state_nxt = REQ;

      REQ: begin
        // An accepted request always owes a response, so a redirect must drain it.
        if (mem_req_ready)
          w_state_nxt = redirect_valid ? DRAIN : WAIT;
        else if (w_redir_mis)
          w_state_nxt = HOLD;
      end

      WAIT: begin
        if (redirect_valid) begin
          if (mem_rsp_valid)
            w_state_nxt = w_redir_mis ? HOLD : REQ;
          else
            w_state_nxt = DRAIN;
        end else if (mem_rsp_valid) begin
          w_inst_nxt  = mem_rsp_data;
          w_state_nxt = HOLD;
        end
      end

      DRAIN: begin
        if (mem_rsp_valid)
          w_state_nxt = w_mis_nxt ? HOLD : REQ;
      end

      HOLD: begin
        if (redirect_valid) begin
          w_state_nxt = w_redir_mis ? HOLD : REQ;
        end else if (out_ready) begin
          w_pc_nxt    = pc_align(r_pc + XLEN'(4));
          w_mis_nxt   = 1'b0;
          w_state_nxt = REQ;
        end
      end

      default: w_state_nxt = BOOT;
    endcase

    // A trapped redirect presents a NOP in place of a fetched word.
    if ((w_state_nxt == HOLD) && w_mis_nxt)
      w_inst_nxt = NOP_INST;
  end

  assign mem_req_valid = (r_state == REQ);
  assign mem_req_addr  = r_pc;
  assign out_valid     = (r_state == HOLD);
  assign out_pc        = r_pc;
  assign out_inst      = r_inst;

`ifdef IFU32_MISALIGN_TRAP_EN
  assign out_misalign  = r_mis && (r_state == HOLD);
`endif

  inst_field_split u_split (
    .inst   (r_inst),
    .opcode (out_opcode),
    .funct3 (out_funct3),
    .funct7 (out_funct7)
  );

endmodule

`default_nettype wire

// File: tb/tb_ifu32_fetch.sv
// ============================================================================
// Module   : tb_ifu32_fetch
// Brief    : Self-checking bench for ifu32_fetch (vectors, corner sequences, random).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ifu32_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [6:0]  out_opcode;
  logic [3:0]  out_funct3;
  logic [7:0]  out_funct7;
`ifdef IFU32_MISALIGN_TRAP_EN
  logic        out_misalign;
`endif

  always #5 clk = ~clk;

  ifu32_fetch #(.RESET_PC(32'h8000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .out_opcode     (out_opcode),
    .out_funct3     (out_funct3),
`ifdef IFU32_MISALIGN_TRAP_EN
    .out_misalign   (out_misalign),
`endif
    .out_funct7     (out_funct7)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] inst;
    logic [6:0]  opc;
    logic [3:0]  f3;
    logic [7:0]  f7;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0BAD_F00D;
  endfunction

  // Starts with the DUT presenting a request; ends with it presenting the next one.
  task automatic fetch_vec(input logic [31:0] inst, input logic [31:0] addr,
                           input logic [6:0] opc, input logic [3:0] f3, input logic [7:0] f7);
    chk("req_valid", {31'b0, mem_req_valid}, 32'd1);
    chk("req_addr", mem_req_addr, addr);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("wait_out_valid", {31'b0, out_valid}, 32'd0);
    chk("wait_req_valid", {31'b0, mem_req_valid}, 32'd0);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = inst;
    tick();
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 32'h0;
    chk("hold_out_valid", {31'b0, out_valid}, 32'd1);
    chk("hold_out_pc", out_pc, addr);
    chk("hold_out_inst", out_inst, inst);
    chk("opcode", {25'b0, out_opcode}, {25'b0, opc});
    chk("funct3", {28'b0, out_funct3}, {28'b0, f3});
    chk("funct7", {24'b0, out_funct7}, {24'b0, f7});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  logic [31:0] exp_pc;
  logic [31:0] pend_addr;
  logic [31:0] w;
  logic        pend;
  int          lat;
  int          delivered;

  initial begin
    vecs[0] = '{32'h0020_8133, 7'h33, 4'h0, 8'h00};
    vecs[1] = '{32'hFFFF_FFFF, 7'h7F, 4'h7, 8'h7F};
    vecs[2] = '{32'h4000_D0B3, 7'h33, 4'h5, 8'h20};
    vecs[3] = '{32'h0000_0013, 7'h13, 4'h0, 8'h00};
    vecs[4] = '{32'h0000_7000, 7'h00, 4'h7, 8'h00};

    rst_n = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_inst", out_inst, 32'h0);

    // Redirect during the boot cycle must be ignored.
    rst_n = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h1234_5670;
    chk("boot_req_valid", {31'b0, mem_req_valid}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    chk("boot_redirect_ignored", mem_req_addr, 32'h8000_0000);

    for (int i = 0; i < 5; i++)
      fetch_vec(vecs[i].inst, 32'h8000_0000 + 32'(4 * i), vecs[i].opc, vecs[i].f3, vecs[i].f7);

    // Backpressure: five stalled cycles in HOLD.
    mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1111_1113; tick(); mem_rsp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_no_req", {31'b0, mem_req_valid}, 32'd0);
      chk("bp_inst_stable", out_inst, 32'h1111_1113);
      chk("bp_pc_stable", out_pc, 32'h8000_0014);
      tick();
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("bp_next_req", {31'b0, mem_req_valid}, 32'd1);
    chk("bp_next_addr", mem_req_addr, 32'h8000_0018);

    // Redirect while waiting: stale response must not reach decode.
    mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0100; tick(); redirect_valid = 1'b0;
    chk("drain_no_req", {31'b0, mem_req_valid}, 32'd0);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEAD_BEEF; tick(); mem_rsp_valid = 1'b0;
    chk("stale_not_out", {31'b0, out_valid}, 32'd0);
    chk("redir_addr", mem_req_addr, 32'h8000_0100);
    fetch_vec(vecs[3].inst, 32'h8000_0100, vecs[3].opc, vecs[3].f3, vecs[3].f7);

    // Redirect in REQ without handshake, then redirect coinciding with acceptance.
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0008; tick(); redirect_valid = 1'b0;
    chk("req_redir_valid", {31'b0, mem_req_valid}, 32'd1);
    chk("req_redir_addr", mem_req_addr, 32'h8000_0008);
    mem_req_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
    tick();
    mem_req_ready = 1'b0; redirect_valid = 1'b0;
    chk("hs_redir_drain", {31'b0, mem_req_valid}, 32'd0);
    tick();
    chk("hs_redir_drain_hold", {31'b0, mem_req_valid}, 32'd0);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hBAD0_0013; tick(); mem_rsp_valid = 1'b0;
    chk("hs_redir_no_out", {31'b0, out_valid}, 32'd0);
    fetch_vec(vecs[2].inst, 32'h8000_0200, vecs[2].opc, vecs[2].f3, vecs[2].f7);

    // PC wrap.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; tick(); redirect_valid = 1'b0;
    fetch_vec(vecs[0].inst, 32'hFFFF_FFFC, vecs[0].opc, vecs[0].f3, vecs[0].f7);
    chk("wrap_addr", mem_req_addr, 32'h0000_0000);

    // Async reset while holding an instruction.
    mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1234_5613; tick(); mem_rsp_valid = 1'b0;
    chk("pre_rst_hold", {31'b0, out_valid}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("async_rst_out_inst", out_inst, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Async reset while waiting; responses during reset and boot are ignored.
    chk("rst2_addr", mem_req_addr, 32'h8000_0000);
    mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("async_wait_req_valid", {31'b0, mem_req_valid}, 32'd0);
    chk("async_wait_out_valid", {31'b0, out_valid}, 32'd0);
    tick();
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hCAFE_F00D;
    tick();
    rst_n = 1'b1;
    tick();
    mem_rsp_valid = 1'b0;
    chk("post_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("post_rst_out_inst", out_inst, 32'h0);
    chk("post_rst_req_valid", {31'b0, mem_req_valid}, 32'd1);
    chk("post_rst_addr", mem_req_addr, 32'h8000_0000);

`ifdef IFU32_MISALIGN_TRAP_EN
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0102; tick(); redirect_valid = 1'b0;
    chk("mis_out_valid", {31'b0, out_valid}, 32'd1);
    chk("mis_no_req", {31'b0, mem_req_valid}, 32'd0);
    chk("mis_out_pc", out_pc, 32'h8000_0102);
    chk("mis_out_inst", out_inst, 32'h0000_0013);
    chk("mis_flag", {31'b0, out_misalign}, 32'd1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("mis_flag_clr", {31'b0, out_misalign}, 32'd0);
    chk("mis_next_req", {31'b0, mem_req_valid}, 32'd1);
    chk("mis_next_addr", mem_req_addr, 32'h8000_0104);
`endif

    // Randomized run against a PC-stream reference model.
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    exp_pc = 32'h8000_0000; pend = 1'b0; lat = 0; delivered = 0; pend_addr = 32'h0;
    for (int c = 0; c < 4000; c++) begin
      if (mem_req_valid) begin
        chk("rnd_req_addr", mem_req_addr, exp_pc);
        chk("rnd_one_outstanding", {31'b0, pend}, 32'd0);
      end
      if (out_valid) begin
        w = memf(exp_pc);
        chk("rnd_out_pc", out_pc, exp_pc);
        chk("rnd_out_inst", out_inst, w);
        chk("rnd_opcode", {25'b0, out_opcode}, w % 128);
        chk("rnd_funct3", {28'b0, out_funct3}, (w >> 12) % 8);
        chk("rnd_funct7", {24'b0, out_funct7}, w >> 25);
      end

      mem_req_ready = ($urandom_range(0, 2) != 0);
      if (pend && lat == 0) begin
        mem_rsp_valid = 1'b1; mem_rsp_data = memf(pend_addr);
      end else begin
        mem_rsp_valid = 1'b0; mem_rsp_data = $urandom;
      end
      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
`ifdef IFU32_MISALIGN_TRAP_EN
      redirect_pc    = $urandom & 32'hFFFF_FFFC;
`else
      redirect_pc    = $urandom;
`endif

      if (out_valid && out_ready) begin
        delivered++;
        exp_pc = exp_pc + 32'd4;
      end
      if (redirect_valid) exp_pc = redirect_pc & 32'hFFFF_FFFC;
      if (mem_rsp_valid) pend = 1'b0;
      else if (pend && lat > 0) lat--;
      if (mem_req_valid && mem_req_ready) begin
        pend = 1'b1; pend_addr = mem_req_addr; lat = $urandom_range(0, 3);
      end
      tick();
    end
    chk("rnd_progress", {31'b0, (delivered > 150)}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
